// File: rtl/sos_pkg.sv
// Shared constants for the SOS sequencer and the function_module letter generator:
// letter select codes, sequencer state encoding and the default 1 ms prescale value.
package sos_pkg;

    localparam logic [15:0] T1MS_DEFAULT = 16'd49_999;

    localparam logic [1:0] LETTER_S    = 2'b10;
    localparam logic [1:0] LETTER_O    = 2'b01;
    localparam logic [1:0] LETTER_NONE = 2'b00;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_GAP   = 3'd2;
    localparam logic [2:0] ST_WGAP  = 3'd3;
    localparam logic [2:0] ST_FIN   = 3'd4;

    // Letter index 0/1/2 of the word S-O-S.
    function automatic logic [1:0] letter_code(input logic [1:0] idx);
        return (idx == 2'd1) ? LETTER_O : LETTER_S;
    endfunction

endpackage

// File: rtl/sos_sequencer_ms_timer.sv
// Millisecond gap timer: prescaler wraps every T1MS+1 cycles and advances a ms count;
// hit is high while the ms count equals target. clr restarts both counters.
module ms_timer #(
    parameter logic [15:0] T1MS = sos_pkg::T1MS_DEFAULT
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       clr,
    input  logic [9:0] target,
    output logic       hit
);

    logic [15:0] presc_reg;
    logic [9:0]  ms_reg;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            presc_reg <= 16'd0;
            ms_reg    <= 10'd0;
        end else if (clr) begin
            presc_reg <= 16'd0;
            ms_reg    <= 10'd0;
        end else if (presc_reg == T1MS) begin
            presc_reg <= 16'd0;
            ms_reg    <= ms_reg + 10'd1;
        end else begin
            presc_reg <= presc_reg + 16'd1;
        end
    end

    assign hit = (ms_reg == target);

endmodule

// File: rtl/sos_sequencer.sv
// Drives function_module through the letters S-O-S with letter/word gaps, REPEAT words per trigger
// (0 = continuous). Optional SOS_ABORT_EN adds stop_sig to end the sequence early.
module sos_sequencer
    import sos_pkg::*;
#(
    parameter logic [15:0] T1MS          = T1MS_DEFAULT,
    parameter logic [9:0]  LETTER_GAP_MS = 10'd150,
    parameter logic [9:0]  WORD_GAP_MS   = 10'd700,
    parameter logic [7:0]  REPEAT        = 8'd3
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       trig_sig,
    input  logic       func_done_sig,
`ifdef SOS_ABORT_EN
    input  logic       stop_sig,
`endif
    output logic [1:0] func_start_sig,
    output logic       func_en_sig,
    output logic       busy_sig,
    output logic       seq_done_sig
);

    logic [2:0] state_reg, state_next;
    logic [1:0] idx_reg, idx_next;
    logic [7:0] word_reg, word_next;
    logic [1:0] start_reg, start_next;
    logic       en_reg, en_next;
    logic       busy_reg, busy_next;
    logic       done_reg, done_next;
    logic       abort_req;
    logic       gap_hit;
    logic       timer_clr;
    logic [9:0] gap_target;

`ifdef SOS_ABORT_EN
    // A stop seen mid-letter is remembered so the letter can finish before FIN.
    logic stop_pend_reg;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            stop_pend_reg <= 1'b0;
        end else if (state_reg == ST_IDLE) begin
            stop_pend_reg <= 1'b0;
        end else if (state_reg == ST_ISSUE && stop_sig) begin
            stop_pend_reg <= 1'b1;
        end
    end

    assign abort_req = stop_pend_reg | stop_sig;
`else
    assign abort_req = 1'b0;
`endif

    assign timer_clr  = (state_next != state_reg);
    assign gap_target = (state_reg == ST_WGAP) ? WORD_GAP_MS : LETTER_GAP_MS;

    ms_timer #(.T1MS(T1MS)) u_ms_timer (
        .CLK    (CLK),
        .RSTn   (RSTn),
        .clr    (timer_clr),
        .target (gap_target),
        .hit    (gap_hit)
    );

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        word_next  = word_reg;
        start_next = start_reg;
        en_next    = en_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (trig_sig) begin
                    state_next = ST_ISSUE;
                    idx_next   = 2'd0;
                    word_next  = 8'd0;
                    busy_next  = 1'b1;
                    en_next    = 1'b1;
                    start_next = letter_code(2'd0);
                end
            end
            ST_ISSUE: begin
                // Drop enable on the done edge so the generator cannot restart after its wrap.
                if (func_done_sig) begin
                    en_next    = 1'b0;
                    start_next = LETTER_NONE;
                    if (idx_reg < 2'd2) begin
                        state_next = ST_GAP;
                    end else begin
                        state_next = ST_WGAP;
                        word_next  = word_reg + 8'd1;
                    end
                end
            end
            ST_GAP: begin
                if (abort_req) begin
                    state_next = ST_FIN;
                    done_next  = 1'b1;
                end else if (gap_hit) begin
                    state_next = ST_ISSUE;
                    idx_next   = idx_reg + 2'd1;
                    en_next    = 1'b1;
                    start_next = letter_code(idx_reg + 2'd1);
                end
            end
            ST_WGAP: begin
                if (abort_req || (REPEAT != 8'd0 && word_reg == REPEAT)) begin
                    state_next = ST_FIN;
                    done_next  = 1'b1;
                end else if (gap_hit) begin
                    state_next = ST_ISSUE;
                    idx_next   = 2'd0;
                    en_next    = 1'b1;
                    start_next = letter_code(2'd0);
                end
            end
            ST_FIN: begin
                state_next = ST_IDLE;
                busy_next  = 1'b0;
            end
            default: begin
                state_next = ST_IDLE;
                en_next    = 1'b0;
                start_next = LETTER_NONE;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_reg <= ST_IDLE;
            idx_reg   <= 2'd0;
            word_reg  <= 8'd0;
            start_reg <= LETTER_NONE;
            en_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            word_reg  <= word_next;
            start_reg <= start_next;
            en_reg    <= en_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign func_start_sig = start_reg;
    assign func_en_sig    = en_reg;
    assign busy_sig       = busy_reg;
    assign seq_done_sig   = done_reg;

endmodule

// File: doc/sos_sequencer.md
# sos_sequencer

Controller that drives the buzzer letter generator (`function_module`) to sound the Morse word S-O-S. On a trigger it issues each letter through the generator's start/enable/done handshake and inserts the letter and word gaps. It repeats the word a configured number of times, or continuously. It sits between the top-level trigger/key logic and `function_module`, and is the generator's only master.

## Interface
- `T1MS`, 16'd49_999: clock cycles per 1 ms tick, minus 1 (50 MHz clock).
- `LETTER_GAP_MS`, 10'd150: silence between letters, in ms.
- `WORD_GAP_MS`, 10'd700: silence between words, in ms.
- `REPEAT`, 8'd3: number of words per trigger. 0 = continuous.
- `CLK` input 1: single clock, rising edge.
- `RSTn` input 1: asynchronous, active-low reset.
- `trig_sig` input 1: start request. Sampled only in IDLE; level or pulse both accepted.
- `func_done_sig` input 1: one-cycle done pulse from the generator.
- `func_start_sig` output 2: letter select. 2'b10 = S, 2'b01 = O, 2'b00 = none.
- `func_en_sig` output 1: generator enable.
- `busy_sig` output 1: high from the first letter issue until return to IDLE.
- `seq_done_sig` output 1: one-cycle pulse when the final word completes.

## Operation
- Reset values: `func_start_sig`=2'b00, `func_en_sig`=0, `busy_sig`=0, `seq_done_sig`=0. The state machine is in IDLE, and the letter index, word counter and timers are all 0.
- States: IDLE, ISSUE, GAP, WGAP, FIN.
- **IDLE**
  - `trig_sig`=1 → ISSUE. Set letter index 0, word counter 0, `busy_sig`=1.
- **ISSUE**
  - Drive `func_en_sig`=1 and `func_start_sig` = S/O/S for letter index 0/1/2.
  - Both outputs are held stable until `func_done_sig` is sampled high.
  - On that same edge, both outputs are cleared to 0. This stops the generator from re-starting after its internal wrap.
  - Then go to GAP if the letter index is below 2, otherwise to WGAP.
- **GAP**
  - Outputs idle. Count `LETTER_GAP_MS` ticks.
  - Then increment the letter index and go to ISSUE.
- **WGAP** (reached after the third letter)
  - Increment the word counter.
  - If `REPEAT`≠0 and word counter = `REPEAT` → FIN, with no trailing word gap.
  - Otherwise, count `WORD_GAP_MS` ticks, reset the letter index to 0, and go to ISSUE.
- **FIN**: `seq_done_sig`=1 for one cycle, `busy_sig`=0 → IDLE.
- `trig_sig` is ignored in every state except IDLE. There is no queueing.
- `func_done_sig` is ignored outside ISSUE.
- Timer: a 16-bit prescaler is cleared on every state entry and counts 0..`T1MS`. A 10-bit ms counter increments on prescaler wrap. A gap ends on the cycle the ms counter equals the target.
- A gap parameter of 0 means the gap state lasts exactly 1 cycle.
- The word counter is 8 bits. With `REPEAT`=0 it wraps freely and is never compared.
- `RSTn` low at any time, including mid-letter, forces the reset values immediately. The generator, sharing `RSTn`, resets together with the sequencer.

## Timing
- IDLE to the first letter: 1 cycle. `trig_sig` high at edge n gives `func_en_sig`=1 after edge n.
- Done to disable: `func_done_sig` high at edge m gives `func_en_sig`=0 and `func_start_sig`=0 after edge m.
- Disable to next letter issue: `LETTER_GAP_MS`×(`T1MS`+1)+1 cycles.
- Between words the same rule applies, using `WORD_GAP_MS`.
- Last done to `seq_done_sig`: 2 cycles (WGAP evaluate, then FIN).
- Last done to IDLE: 3 cycles.

## Configuration
- `SOS_ABORT_EN` defined:
  - Adds input `stop_sig` (1 bit).
  - `stop_sig` high in ISSUE: the current letter runs to its done pulse, then the sequencer goes to FIN.
  - `stop_sig` high in GAP or WGAP: go to FIN on the next edge.
  - In both cases `seq_done_sig` pulses as normal.
- `SOS_ABORT_EN` undefined: no `stop_sig` port; the sequence always runs to completion.

## Structure
- Shared package `sos_pkg`:
  - `LETTER_S`=2'b10, `LETTER_O`=2'b01, `LETTER_NONE`=2'b00.
  - State encoding.
  - Default `T1MS`. This same constant is also used by `function_module`.
- One sub-module: `ms_timer`. It contains the prescaler and ms counter, with ports `clr`, `target[9:0]`, `hit`.

## Test plan
Bench parameters: `T1MS`=9, `LETTER_GAP_MS`=3, `WORD_GAP_MS`=7, `REPEAT`=2. The generator model asserts done 20 cycles after enable.

- **Single trigger**: pulse `trig_sig` → `func_start_sig` sequence 10,01,10,10,01,10, each letter gap 31 cycles, one word gap 71 cycles, one `seq_done_sig` pulse, `busy_sig` low after.
- **Handshake hold**: check `func_en_sig`/`func_start_sig` are stable for all 20 cycles. Both must be 0 on the cycle after `func_done_sig`.
- **Trigger while busy**: hold `trig_sig`=1 throughout → exactly 6 letters, then a new sequence starts 1 cycle after IDLE is re-entered.
- **Continuous mode** (`REPEAT`=0): observe ≥4 words with no `seq_done_sig`; assert reset mid-O → all outputs 0 immediately, IDLE after release.
- **Spurious done**: pulse `func_done_sig` in GAP → ignored; the letter index still advances only after the gap.
- **Abort** (`SOS_ABORT_EN`): `stop_sig` during the second letter → that O completes, no third letter, `seq_done_sig` 2 cycles after its done.
